// File: rtl/rv32_bus_arbiter_if.sv
// rv32 fetch/data/memory port bundle for the shared bus arbiter.
// slave = arbiter view, master = core plus memory view.
interface rv32_bus_arbiter_if;
  logic [31:0] instr_address_in;
  logic        instr_read_in;
  logic [31:0] instr_read_value_out;
  logic        instr_ready_out;
  logic [31:0] data_address_in;
  logic        data_read_in;
  logic        data_write_in;
  logic [3:0]  data_write_mask_in;
  logic [31:0] data_write_value_in;
  logic [31:0] data_read_value_out;
  logic        data_ready_out;
  logic [31:0] bus_address_out;
  logic        bus_read_out;
  logic        bus_write_out;
  logic [3:0]  bus_write_mask_out;
  logic [31:0] bus_write_value_out;
  logic [31:0] bus_read_value_in;
  logic        bus_ready_in;
  logic [1:0]  grant_out;

  modport slave (
    input  instr_address_in, instr_read_in,
    output instr_read_value_out, instr_ready_out,
    input  data_address_in, data_read_in,
    input  data_write_in, data_write_mask_in,
    input  data_write_value_in,
    output data_read_value_out, data_ready_out,
    output bus_address_out, bus_read_out,
    output bus_write_out, bus_write_mask_out,
    output bus_write_value_out,
    input  bus_read_value_in, bus_ready_in,
    output grant_out
  );

  modport master (
    output instr_address_in, instr_read_in,
    input  instr_read_value_out, instr_ready_out,
    output data_address_in, data_read_in,
    output data_write_in, data_write_mask_in,
    output data_write_value_in,
    input  data_read_value_out, data_ready_out,
    input  bus_address_out, bus_read_out,
    input  bus_write_out, bus_write_mask_out,
    input  bus_write_value_out,
    output bus_read_value_in, bus_ready_in,
    input  grant_out
  );
endinterface

// File: rtl/rv32_bus_arbiter.sv
// Shares one memory port between rv32 fetch and data buses.
// Data has priority; a streak counter bounds fetch starvation.
module rv32_bus_arbiter #(
  parameter int unsigned DATA_BURST_MAX = 4
) (
  input logic                clk,
  input logic                reset_n,
  rv32_bus_arbiter_if.slave  io
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    INSTR = 2'b01,
    DATA  = 2'b10
  } state_t;

  localparam logic [3:0] BMAX = 4'(DATA_BURST_MAX);

  state_t     state;
  logic [3:0] streak;
  logic [3:0] streak_inc;
  logic       ireq;
  logic       dreq;
  logic       d_win;
  logic       go_d;
  logic       go_i;
  logic       go_idle;

  assign ireq       = io.instr_read_in;
  assign dreq       = io.data_read_in | io.data_write_in;
  assign d_win      = dreq & (~ireq | (streak < BMAX));
  assign streak_inc = (streak == 4'hf) ? streak : streak + 4'd1;

  // Next-owner decision; completion hands over to the other master only.
  always_comb begin
    go_d    = 1'b0;
    go_i    = 1'b0;
    go_idle = 1'b0;
    unique case (state)
      IDLE: begin
        go_d = d_win;
        go_i = ~d_win & ireq;
      end
      INSTR: begin
        go_d    = io.bus_ready_in & dreq;
        go_idle = io.bus_ready_in & ~dreq;
      end
      DATA: begin
        go_i    = io.bus_ready_in & ireq;
        go_idle = io.bus_ready_in & ~ireq;
      end
      default: go_idle = 1'b1;
    endcase
  end

  // Owner state, streak counter and the registered memory-side request.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state                  <= IDLE;
      streak                 <= 4'd0;
      io.bus_address_out     <= 32'd0;
      io.bus_read_out        <= 1'b0;
      io.bus_write_out       <= 1'b0;
      io.bus_write_mask_out  <= 4'd0;
      io.bus_write_value_out <= 32'd0;
    end else if (go_d) begin
      state                  <= DATA;
      if (ireq) streak       <= streak_inc;
      io.bus_address_out     <= io.data_address_in;
      io.bus_read_out        <= io.data_read_in;
      io.bus_write_out       <= io.data_write_in;
      io.bus_write_mask_out  <= io.data_write_mask_in;
      io.bus_write_value_out <= io.data_write_value_in;
    end else if (go_i) begin
      state                  <= INSTR;
      streak                 <= 4'd0;
      io.bus_address_out     <= io.instr_address_in;
      io.bus_read_out        <= 1'b1;
      io.bus_write_out       <= 1'b0;
      io.bus_write_mask_out  <= 4'd0;
      io.bus_write_value_out <= 32'd0;
    end else if (go_idle) begin
      state                  <= IDLE;
      io.bus_read_out        <= 1'b0;
      io.bus_write_out       <= 1'b0;
      io.bus_write_mask_out  <= 4'd0;
    end
  end

  assign io.grant_out = state;

  // Completion is reported only to a master still asserting its request.
  assign io.instr_ready_out =
    io.bus_ready_in & (state == INSTR) & ireq;
  assign io.data_ready_out =
    io.bus_ready_in & (state == DATA) & dreq;

  assign io.instr_read_value_out = io.bus_read_value_in;
  assign io.data_read_value_out  = io.bus_read_value_in;

endmodule

// File: tb/tb_rv32_bus_arbiter.sv
// Bench for rv32_bus_arbiter: directed scenarios plus random
// traffic checked against a transaction-level reference model.
module tb_rv32_bus_arbiter;

  localparam int MAX = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  always #5 clk = ~clk;

  rv32_bus_arbiter_if io ();

  rv32_bus_arbiter #(
    .DATA_BURST_MAX(MAX)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .io     (io)
  );

  int checks = 0;
  int errors = 0;

  // reference model: owner 0 none, 1 fetch, 2 data
  int          m_owner;
  int          m_streak;
  logic [31:0] m_addr;
  logic [31:0] m_wv;
  logic        m_rd;
  logic        m_wr;
  logic [3:0]  m_mask;

  logic [31:0] snap_addr;
  logic [31:0] snap_wv;
  logic [3:0]  snap_mask;
  logic        snap_rd;
  logic        snap_wr;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner  = 0;
    m_streak = 0;
    m_addr   = 32'd0;
    m_wv     = 32'd0;
    m_rd     = 1'b0;
    m_wr     = 1'b0;
    m_mask   = 4'd0;
  endtask

  // one clock edge of the model, from the current inputs
  task automatic model_clock();
    bit ir;
    bit dq;
    int nxt;
    ir = io.instr_read_in;
    dq = io.data_read_in | io.data_write_in;
    if (m_owner != 0 && !io.bus_ready_in) return;
    if (m_owner == 0) begin
      if (dq && (!ir || m_streak < MAX)) nxt = 2;
      else if (ir) nxt = 1;
      else nxt = 0;
    end else if (m_owner == 1) begin
      nxt = dq ? 2 : 0;
    end else begin
      nxt = ir ? 1 : 0;
    end
    if (nxt == 2) begin
      if (ir) m_streak = (m_streak + 1 > 15) ? 15 : m_streak + 1;
      m_addr = io.data_address_in;
      m_rd   = io.data_read_in;
      m_wr   = io.data_write_in;
      m_mask = io.data_write_mask_in;
      m_wv   = io.data_write_value_in;
    end else if (nxt == 1) begin
      m_streak = 0;
      m_addr   = io.instr_address_in;
      m_rd     = 1'b1;
      m_wr     = 1'b0;
      m_mask   = 4'd0;
      m_wv     = 32'd0;
    end else begin
      m_rd   = 1'b0;
      m_wr   = 1'b0;
      m_mask = 4'd0;
    end
    m_owner = nxt;
  endtask

  task automatic check_model();
    bit ir;
    bit dq;
    bit rdy;
    ir  = io.instr_read_in;
    dq  = io.data_read_in | io.data_write_in;
    rdy = io.bus_ready_in;
    chk("grant", 32'(io.grant_out), 32'(m_owner));
    chk("streak", 32'(dut.streak), 32'(m_streak));
    chk("addr", io.bus_address_out, m_addr);
    chk("rd", 32'(io.bus_read_out), 32'(m_rd));
    chk("wr", 32'(io.bus_write_out), 32'(m_wr));
    chk("mask", 32'(io.bus_write_mask_out), 32'(m_mask));
    chk("wval", io.bus_write_value_out, m_wv);
    chk("iready", 32'(io.instr_ready_out),
        32'(rdy && m_owner == 1 && ir));
    chk("dready", 32'(io.data_ready_out),
        32'(rdy && m_owner == 2 && dq));
    chk("ival", io.instr_read_value_out, io.bus_read_value_in);
    chk("dval", io.data_read_value_out, io.bus_read_value_in);
  endtask

  // called just after a negedge with inputs already set
  task automatic step();
    #1;
    check_model();
    @(posedge clk);
    model_clock();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    io.instr_address_in    = 32'd0;
    io.instr_read_in       = 1'b0;
    io.data_address_in     = 32'd0;
    io.data_read_in        = 1'b0;
    io.data_write_in       = 1'b0;
    io.data_write_mask_in  = 4'd0;
    io.data_write_value_in = 32'd0;
    io.bus_read_value_in   = 32'd0;
    io.bus_ready_in        = 1'b0;
  endtask

  task automatic drain();
    clear_inputs();
    io.bus_ready_in = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (m_owner == 0) break;
      step();
    end
    io.bus_ready_in = 1'b0;
    #1;
    chk("drain_idle", 32'(io.grant_out), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    clear_inputs();
    model_reset();
    reset_n = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_grant", 32'(io.grant_out), 32'd0);
    chk("rst_rd", 32'(io.bus_read_out), 32'd0);
    io.bus_read_value_in = 32'hcafef00d;
    io.bus_ready_in = 1'b1;
    #1;
    chk("rst_dready", 32'(io.data_ready_out), 32'd0);
    chk("rst_pass", io.data_read_value_out, 32'hcafef00d);
    @(negedge clk);
    clear_inputs();
    reset_n = 1'b1;
    step();

    // lone fetch, single-cycle memory
    io.instr_read_in    = 1'b1;
    io.instr_address_in = 32'h100;
    step();
    io.bus_ready_in      = 1'b1;
    io.bus_read_value_in = 32'hdeadbeef;
    #1;
    chk("lf_grant", 32'(io.grant_out), 32'd1);
    chk("lf_rd", 32'(io.bus_read_out), 32'd1);
    chk("lf_addr", io.bus_address_out, 32'h100);
    chk("lf_iready", 32'(io.instr_ready_out), 32'd1);
    chk("lf_ival", io.instr_read_value_out, 32'hdeadbeef);
    step();
    clear_inputs();
    #1;
    chk("lf_idle", 32'(io.grant_out), 32'd0);
    step();

    // contention from IDLE: data first, then fetch back-to-back
    io.instr_read_in       = 1'b1;
    io.instr_address_in    = 32'h200;
    io.data_write_in       = 1'b1;
    io.data_address_in     = 32'h300;
    io.data_write_mask_in  = 4'hf;
    io.data_write_value_in = 32'h12345678;
    step();
    #1;
    chk("ct_grant", 32'(io.grant_out), 32'd2);
    chk("ct_wr", 32'(io.bus_write_out), 32'd1);
    chk("ct_mask", 32'(io.bus_write_mask_out), 32'hf);
    chk("ct_wv", io.bus_write_value_out, 32'h12345678);
    io.bus_ready_in = 1'b1;
    step();
    io.data_write_in = 1'b0;
    io.bus_ready_in  = 1'b0;
    #1;
    chk("ct_igrant", 32'(io.grant_out), 32'd1);
    chk("ct_iwr", 32'(io.bus_write_out), 32'd0);
    chk("ct_imask", 32'(io.bus_write_mask_out), 32'd0);
    step();
    drain();

    // starvation guard: two data wins from IDLE, then fetch
    for (int k = 0; k < 3; k++) begin
      clear_inputs();
      io.instr_read_in    = 1'b1;
      io.instr_address_in = 32'h600 + 32'(k);
      io.data_read_in     = 1'b1;
      io.data_address_in  = 32'h700 + 32'(k);
      step();
      #1;
      chk("sg_grant", 32'(io.grant_out), (k < MAX) ? 32'd2 : 32'd1);
      io.instr_read_in = 1'b0;
      io.data_read_in  = 1'b0;
      io.bus_ready_in  = 1'b1;
      step();
      io.bus_ready_in = 1'b0;
      step();
    end
    #1;
    chk("sg_streak", 32'(dut.streak), 32'd0);
    @(negedge clk);

    // wait states on a data read, fetch waiting behind it
    clear_inputs();
    io.data_read_in     = 1'b1;
    io.data_address_in  = 32'h400;
    io.instr_read_in    = 1'b1;
    io.instr_address_in = 32'h404;
    io.bus_read_value_in = 32'h0badf00d;
    step();
    #1;
    snap_addr = io.bus_address_out;
    snap_wv   = io.bus_write_value_out;
    snap_mask = io.bus_write_mask_out;
    snap_rd   = io.bus_read_out;
    snap_wr   = io.bus_write_out;
    chk("ws_rd", 32'(snap_rd), 32'd1);
    for (int c = 1; c <= 5; c++) begin
      io.bus_ready_in = (c == 5);
      #1;
      chk("ws_addr", io.bus_address_out, snap_addr);
      chk("ws_rdh", 32'(io.bus_read_out), 32'(snap_rd));
      chk("ws_wrh", 32'(io.bus_write_out), 32'(snap_wr));
      chk("ws_mask", 32'(io.bus_write_mask_out), 32'(snap_mask));
      chk("ws_wv", io.bus_write_value_out, snap_wv);
      chk("ws_dready", 32'(io.data_ready_out), 32'(c == 5));
      chk("ws_iready", 32'(io.instr_ready_out), 32'd0);
      step();
    end
    drain();

    // fetch drops its request two cycles into the grant
    clear_inputs();
    io.instr_read_in    = 1'b1;
    io.instr_address_in = 32'h500;
    step();
    step();
    step();
    io.instr_read_in = 1'b0;
    step();
    io.bus_ready_in = 1'b1;
    #1;
    chk("dr_rd", 32'(io.bus_read_out), 32'd1);
    chk("dr_addr", io.bus_address_out, 32'h500);
    chk("dr_iready", 32'(io.instr_ready_out), 32'd0);
    step();
    io.bus_ready_in = 1'b0;
    #1;
    chk("dr_idle", 32'(io.grant_out), 32'd0);
    step();

    // reset pulse in the middle of a data write
    clear_inputs();
    io.data_write_in       = 1'b1;
    io.data_address_in     = 32'h800;
    io.data_write_mask_in  = 4'h3;
    io.data_write_value_in = 32'haaaa5555;
    step();
    #2;
    chk("rm_wr_before", 32'(io.bus_write_out), 32'd1);
    reset_n = 1'b0;
    #1;
    model_reset();
    chk("rm_wr", 32'(io.bus_write_out), 32'd0);
    chk("rm_grant", 32'(io.grant_out), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    clear_inputs();
    io.bus_ready_in = 1'b1;
    #1;
    chk("rm_dready", 32'(io.data_ready_out), 32'd0);
    chk("rm_iready", 32'(io.instr_ready_out), 32'd0);
    step();
    io.bus_ready_in = 1'b0;
    step();

    // random traffic against the model
    for (int n = 0; n < 600; n++) begin
      io.instr_read_in       = ($urandom_range(0, 2) != 0);
      io.instr_address_in    = $urandom & 32'hfffffffc;
      io.data_read_in        = ($urandom_range(0, 2) == 0);
      io.data_write_in       = ($urandom_range(0, 2) == 0);
      io.data_address_in     = $urandom;
      io.data_write_mask_in  = 4'($urandom);
      io.data_write_value_in = $urandom;
      io.bus_read_value_in   = $urandom;
      io.bus_ready_in        = ($urandom_range(0, 1) == 1);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
